// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter and the alignment checker:
// FSM state encoding, access size codes and requester port IDs.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    REL  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_align_chk.sv
// Combinational access legality check. Natural alignment also guarantees
// that no halfword or word access can wrap past the top of the 8-bit space.
module mem_align_chk
  import mem_pkg::*;
(
  input  logic [7:0] addr,
  input  logic [1:0] size,
  output logic       err
);

  always_comb begin
    case (size)
      SIZE_BYTE: err = 1'b0;
      SIZE_HALF: err = addr[0];
      SIZE_WORD: err = (addr[1:0] != 2'b00);
      default:   err = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) round-robin arbiter in front of a single RAM
// with a MOV/MOC handshake, alignment checking and a MOC timeout.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int MOC_TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        I_Req,
  input  logic        D_Req,
  input  logic [7:0]  I_Addr,
  input  logic [7:0]  D_Addr,
  input  logic [1:0]  I_Size,
  input  logic [1:0]  D_Size,
  input  logic        D_R_W,
  input  logic [31:0] D_WData,
  output logic        I_Ack,
  output logic        D_Ack,
  output logic        Err,
  output logic [31:0] RData,
  output logic        MOV,
  output logic        R_W,
  output logic [7:0]  Address,
  output logic [1:0]  Size,
  output logic [31:0] DataIn,
  input  logic [31:0] DataOut,
  input  logic        MOC
);

  localparam int CW = (MOC_TIMEOUT > 1) ? $clog2(MOC_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MOC_TIMEOUT - 1);

  state_t        state;
  state_t        next_state;
  logic          last_gnt;
  logic [CW-1:0] count;
  logic          any_req;
  logic          sel_d;
  logic [7:0]    sel_addr;
  logic [1:0]    sel_size;
  logic          sel_err;
  logic          timeout;

  // On a tie the port that was not granted last wins; last_gnt doubles as
  // the owner of the access currently in flight.
  assign any_req  = I_Req | D_Req;
  assign sel_d    = D_Req & (~I_Req | (last_gnt == PORT_I));
  assign sel_addr = sel_d ? D_Addr : I_Addr;
  assign sel_size = sel_d ? D_Size : I_Size;
  assign timeout  = (count == CNT_LAST);

  mem_align_chk u_align_chk (
    .addr (sel_addr),
    .size (sel_size),
    .err  (sel_err)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    I_Ack      = 1'b0;
    D_Ack      = 1'b0;
    case (state)
      IDLE: if (any_req) next_state = sel_err ? DONE : WAIT;
      WAIT: if (MOC || timeout) next_state = REL;
      REL:  if (!MOC) next_state = DONE;
      DONE: begin
        next_state = IDLE;
        I_Ack      = (last_gnt == PORT_I);
        D_Ack      = (last_gnt == PORT_D);
      end
      default: next_state = IDLE;
    endcase
  end

  // RAM-side controls are loaded only by a legal grant and then held until
  // the access completes, so the RAM sees stable Address/Size/R_W/DataIn.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      last_gnt <= PORT_I;
      count    <= '0;
      MOV      <= 1'b0;
      R_W      <= 1'b1;
      Address  <= '0;
      Size     <= SIZE_BYTE;
      DataIn   <= '0;
      RData    <= '0;
      Err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            last_gnt <= sel_d ? PORT_D : PORT_I;
            Err      <= sel_err;
            if (!sel_err) begin
              MOV     <= 1'b1;
              Address <= sel_addr;
              Size    <= sel_size;
              R_W     <= sel_d ? D_R_W : 1'b1;
              DataIn  <= sel_d ? D_WData : '0;
              count   <= '0;
            end
          end
        end
        WAIT: begin
          if (MOC) begin
            MOV <= 1'b0;
            if (R_W) RData <= DataOut;
          end else if (timeout) begin
            MOV <= 1'b0;
            Err <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected Acks,
// an independent negedge monitor checks port, Err, RData, latency and MOV.
module tb_mem_arbiter;

  logic        Clk;
  logic        Reset_n;
  logic        I_Req, D_Req;
  logic [7:0]  I_Addr, D_Addr;
  logic [1:0]  I_Size, D_Size;
  logic        D_R_W;
  logic [31:0] D_WData;
  logic        I_Ack, D_Ack, Err;
  logic [31:0] RData;
  logic        MOV, R_W;
  logic [7:0]  Address;
  logic [1:0]  Size;
  logic [31:0] DataIn, DataOut;
  logic        MOC;

  logic        moc_dead;
  logic [7:0]  mem [0:255];
  logic [7:0]  a1, a2, a3;

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] rdata;
    int          ack_cyc;
    int          mov;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;
  int   mov_cycles = 0;

  mem_arbiter #(.MOC_TIMEOUT(15)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .I_Req   (I_Req),
    .D_Req   (D_Req),
    .I_Addr  (I_Addr),
    .D_Addr  (D_Addr),
    .I_Size  (I_Size),
    .D_Size  (D_Size),
    .D_R_W   (D_R_W),
    .D_WData (D_WData),
    .I_Ack   (I_Ack),
    .D_Ack   (D_Ack),
    .Err     (Err),
    .RData   (RData),
    .MOV     (MOV),
    .R_W     (R_W),
    .Address (Address),
    .Size    (Size),
    .DataIn  (DataIn),
    .DataOut (DataOut),
    .MOC     (MOC)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  // Zero-wait RAM: MOC follows MOV combinationally unless forced dead.
  assign a1      = Address + 8'd1;
  assign a2      = Address + 8'd2;
  assign a3      = Address + 8'd3;
  assign MOC     = MOV & ~moc_dead;
  assign DataOut = {mem[a3], mem[a2], mem[a1], mem[Address]};

  always @(posedge Clk) begin
    if (MOV && MOC && !R_W) begin
      mem[Address] <= DataIn[7:0];
      if (Size != 2'b00) mem[a1] <= DataIn[15:8];
      if (Size == 2'b10) begin
        mem[a2] <= DataIn[23:16];
        mem[a3] <= DataIn[31:24];
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (!Reset_n) begin
      mov_cycles = 0;
    end else begin
      if (MOV) mov_cycles++;
      if (I_Ack || D_Ack) begin
        check_output("ack_exclusive", {31'd0, I_Ack & D_Ack}, 32'd0);
        check_output("ack_expected", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check_output("ack_port", {31'd0, D_Ack}, {31'd0, mon_e.port});
          check_output("ack_err", {31'd0, Err}, {31'd0, mon_e.err});
          check_output("ack_rdata", RData, mon_e.rdata);
          check_output("ack_cycle", cyc, mon_e.ack_cyc);
          check_output("mov_cycles", mov_cycles, mon_e.mov);
        end
        mov_cycles = 0;
      end
    end
  end

  task automatic drive(input logic port, input logic [7:0] addr, input logic [1:0] size,
                       input logic rw, input logic [31:0] wdata);
    if (port) begin
      D_Addr  = addr;
      D_Size  = size;
      D_R_W   = rw;
      D_WData = wdata;
      D_Req   = 1'b1;
    end else begin
      I_Addr = addr;
      I_Size = size;
      I_Req  = 1'b1;
    end
  endtask

  task automatic expect_ack(input logic port, input logic err, input logic [31:0] rdata,
                            input int ack_cyc, input int mov);
    exp_t e;
    e.port    = port;
    e.err     = err;
    e.rdata   = rdata;
    e.ack_cyc = ack_cyc;
    e.mov     = mov;
    sb.push_back(e);
  endtask

  task automatic wait_ack(input logic port, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!(port ? D_Ack : I_Ack) && n < budget);
    check_output(port ? "d_ack_seen" : "i_ack_seen", {31'd0, port ? D_Ack : I_Ack}, 32'd1);
    if (port) D_Req = 1'b0;
    else      I_Req = 1'b0;
  endtask

  // Called at a negedge with the arbiter idle; returns at the next idle negedge.
  task automatic apply_stimulus(input logic port, input logic [7:0] addr, input logic [1:0] size,
                                input logic rw, input logic [31:0] wdata, input logic err,
                                input logic [31:0] rdata, input int lat, input int mov);
    drive(port, addr, size, rw, wdata);
    expect_ack(port, err, rdata, cyc + lat, mov);
    wait_ack(port, lat + 8);
    @(negedge Clk);
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    Reset_n = 1'b1;
    I_Req = 1'b0; D_Req = 1'b0;
    I_Addr = '0; D_Addr = '0; I_Size = '0; D_Size = '0;
    D_R_W = 1'b1; D_WData = '0; moc_dead = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    {mem[8'h03], mem[8'h02], mem[8'h01], mem[8'h00]} = 32'hE3A01005;
    {mem[8'h0B], mem[8'h0A], mem[8'h09], mem[8'h08]} = 32'hCAFEF00D;
    {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} = 32'h11223344;
    {mem[8'hFF], mem[8'hFE], mem[8'hFD], mem[8'hFC]} = 32'h89ABCDEF;

    #2 Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    check_output("rst_mov", {31'd0, MOV}, 32'd0);
    check_output("rst_r_w", {31'd0, R_W}, 32'd1);
    check_output("rst_address", {24'd0, Address}, 32'd0);
    check_output("rst_size", {30'd0, Size}, 32'd0);
    check_output("rst_datain", DataIn, 32'd0);
    check_output("rst_rdata", RData, 32'd0);
    check_output("rst_err", {31'd0, Err}, 32'd0);
    check_output("rst_acks", {30'd0, I_Ack, D_Ack}, 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Tie from reset: D write first, then I (held), then D re-requesting in DONE loses to I.
    n = cyc;
    drive(1'b1, 8'h40, 2'b00, 1'b0, 32'h0000005A);
    drive(1'b0, 8'h08, 2'b10, 1'b1, 32'h0);
    expect_ack(1'b1, 1'b0, 32'h00000000, n + 3, 1);
    expect_ack(1'b0, 1'b0, 32'hCAFEF00D, n + 7, 1);
    wait_ack(1'b1, 12);
    drive(1'b1, 8'h40, 2'b00, 1'b1, 32'h0);
    expect_ack(1'b1, 1'b0, 32'h0000005A, n + 11, 1);
    wait_ack(1'b0, 12);
    wait_ack(1'b1, 12);
    @(negedge Clk);
    check_output("mem_40", {24'd0, mem[8'h40]}, 32'h5A);

    apply_stimulus(1'b0, 8'h00, 2'b10, 1'b1, 32'h0, 1'b0, 32'hE3A01005, 3, 1);

    // Illegal requests complete the cycle after grant without touching the RAM.
    apply_stimulus(1'b1, 8'h21, 2'b01, 1'b0, 32'hAAAAAAAA, 1'b1, 32'hE3A01005, 1, 0);
    apply_stimulus(1'b1, 8'hFE, 2'b10, 1'b1, 32'h0,        1'b1, 32'hE3A01005, 1, 0);
    apply_stimulus(1'b1, 8'hFD, 2'b10, 1'b1, 32'h0,        1'b1, 32'hE3A01005, 1, 0);
    apply_stimulus(1'b0, 8'h00, 2'b11, 1'b1, 32'h0,        1'b1, 32'hE3A01005, 1, 0);
    apply_stimulus(1'b1, 8'hFC, 2'b10, 1'b1, 32'h0,        1'b0, 32'h89ABCDEF, 3, 1);
    apply_stimulus(1'b1, 8'h22, 2'b01, 1'b0, 32'h1234BEEF, 1'b0, 32'h89ABCDEF, 3, 1);
    check_output("mem_21", {24'd0, mem[8'h21]}, 32'h00);
    check_output("mem_22", {24'd0, mem[8'h22]}, 32'hEF);
    check_output("mem_23", {24'd0, mem[8'h23]}, 32'hBE);
    check_output("mem_24", {24'd0, mem[8'h24]}, 32'h00);

    // MOC never arrives: 15 WAIT cycles, REL, then an Err Ack with RData held.
    moc_dead = 1'b1;
    apply_stimulus(1'b1, 8'h10, 2'b10, 1'b1, 32'h0, 1'b1, 32'h89ABCDEF, 17, 15);
    moc_dead = 1'b0;
    apply_stimulus(1'b0, 8'h10, 2'b10, 1'b1, 32'h0, 1'b0, 32'h11223344, 3, 1);

    // Reset in the middle of WAIT aborts silently; the held request is re-served.
    moc_dead = 1'b1;
    drive(1'b1, 8'h08, 2'b10, 1'b1, 32'h0);
    repeat (3) @(negedge Clk);
    check_output("wait_mov", {31'd0, MOV}, 32'd1);
    Reset_n = 1'b0;
    #1;
    check_output("midrst_mov", {31'd0, MOV}, 32'd0);
    check_output("midrst_acks", {30'd0, I_Ack, D_Ack}, 32'd0);
    check_output("midrst_address", {24'd0, Address}, 32'd0);
    check_output("midrst_rdata", RData, 32'd0);
    moc_dead = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    expect_ack(1'b1, 1'b0, 32'hCAFEF00D, cyc + 3, 1);
    wait_ack(1'b1, 12);
    repeat (2) @(negedge Clk);

    check_output("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MOC_TIMEOUT, default 15, meaning the maximum number of cycles spent in WAIT before an access aborts.
REQ-002 SHALL have port Clk, input, 1, the single system clock, rising-edge active.
REQ-003 SHALL have port Reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports I_Req, D_Req, input, 1 each, access request from the instruction port and the data port.
REQ-005 SHALL have ports I_Addr, D_Addr, input, 8 each, byte address.
REQ-006 SHALL have ports I_Size, D_Size, input, 2 each, access size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 SHALL have port D_R_W, input, 1, data-port direction: 1 read, 0 write; the instruction port is read-only.
REQ-008 SHALL have port D_WData, input, 32, data-port write data.
REQ-009 SHALL have ports I_Ack, D_Ack, output, 1 each, one-cycle completion pulse.
REQ-010 SHALL have port Err, output, 1, valid with an Ack; signals misalignment, illegal size or timeout.
REQ-011 SHALL have port RData, output, 32, read data, valid with an Ack.
REQ-012 SHALL have ports MOV, R_W, Address, Size, DataIn, output, 1/1/8/2/32, RAM-side controls.
REQ-013 SHALL have ports DataOut, input, 32, and MOC, input, 1, RAM read data and operation complete.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, REL and DONE.
REQ-015 Requester handshake SHALL be: the requester holds Req and its fields stable until its Ack pulse, then may drop Req or change the fields.
REQ-016 IDLE SHALL grant on a clock edge where any Req=1.
REQ-017 Single requester SHALL win.
REQ-018 When both request, arbitration SHALL be round-robin: the port not granted last wins; the last-grant bit updates at each grant.
REQ-019 At grant, request fields SHALL be checked: Size=11, or Size=01 with Addr[0]=1, or Size=10 with Addr[1:0]!=00 -> Err=1, go to DONE, MOV stays 0 and no RAM access occurs.
REQ-020 A legal grant SHALL register Address, Size, R_W (1 for the I port) and DataIn (D_WData, else 0), set MOV=1, clear the timeout counter, and go to WAIT.
REQ-021 RAM-side outputs SHALL stay stable from grant until DONE.
REQ-022 WAIT SHALL, on sampled MOC=1, capture DataOut into RData (reads only), set MOV=0, and go to REL.
REQ-023 WAIT SHALL otherwise increment the counter; when the counter reaches MOC_TIMEOUT it SHALL set MOV=0 and Err=1 and go to REL.
REQ-024 REL SHALL wait for sampled MOC=0, then go to DONE.
REQ-025 DONE SHALL assert Ack of the granted port for exactly one cycle, with Err and RData valid, then return to IDLE.
REQ-026 A clean legal access SHALL have Ack high in the third cycle after the granting edge.
REQ-027 An error grant SHALL have Ack high in the cycle immediately after the granting edge.
REQ-028 Err SHALL clear on the next grant.
REQ-029 RData SHALL hold its value between reads, and writes SHALL NOT alter it.
REQ-030 Alignment rules SHALL guarantee that no access wraps past address 255 (word at 0xFC legal; 0xFD, 0xFF rejected).
REQ-031 Req from the just-acked port seen in DONE SHALL be ignored, since IDLE re-samples it.

Reset
REQ-032 Reset_n=0 SHALL asynchronously force: state IDLE, MOV=0, R_W=1, Address=0, Size=0, DataIn=0, RData=0, Err=0, I_Ack=D_Ack=0, counter=0, last-grant=I, so D wins the first tie.
REQ-033 Reset mid-access SHALL drop MOV immediately and produce no Ack; after release, pending Req SHALL be re-arbitrated from IDLE.

Structure
REQ-034 Shared package mem_pkg SHALL hold the state encoding, the size codes SIZE_BYTE/SIZE_HALF/SIZE_WORD, and the port IDs PORT_I/PORT_D.
REQ-035 Sub-module mem_align_chk (combinational: Addr, Size -> Err) SHALL be used and SHALL be reused by the future cache.

Verification
REQ-036 Scenario: I read word at 0x00 with RAM holding 0xE3A01005 -> MOV 1 for one WAIT cycle, I_Ack in the 3rd cycle after grant, RData=0xE3A01005, Err=0.
REQ-037 Scenario: I_Req and D_Req (write byte 0x5A at 0x40) both asserted from reset -> D served first, then I; then re-request both -> I served first; Mem[0x40]=0x5A.
REQ-038 Scenario: D halfword at 0x21 and D word at 0xFE -> each D_Ack+Err in the cycle after grant, MOV never asserted.
REQ-039 Scenario: MOC tied 0, D read -> MOV drops after 15 WAIT cycles, D_Ack with Err=1, RData unchanged.
REQ-040 Scenario: Reset_n pulsed low during WAIT -> MOV=0 immediately, no Ack; request reissued after reset completes normally.
